// File: rtl/counter_bank_pkg.sv
// rtl/counter_bank_pkg.sv - shared defaults and max-value helper for counter_bank
package counter_bank_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 4;

  function automatic logic [31:0] max_val(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/counter_bank_chan.sv
// rtl/counter_bank_chan.sv - single up/down counter with clear, load, wrap/saturate and boundary pulse
module counter_bank_chan
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));

  logic step;
  logic bound;

  assign step  = en && !clr && !load;
  assign bound = step && (dir ? (count == MAX) : (count == '0));

  // next_count is exported so the top can register the read port in the same edge
  always_comb begin
    next_count = count;
    if (clr) begin
      next_count = '0;
    end else if (load) begin
      next_count = load_val;
    end else if (en) begin
      if (bound && sat) begin
        next_count = count;
      end else if (dir) begin
        next_count = count + WIDTH'(1);
      end else begin
        next_count = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= next_count;
      ovf   <= bound;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of independent counters with a registered read port
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SELW     = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       sat,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       ovf,
  input  logic [SELW-1:0]           rd_sel,
  output logic [WIDTH-1:0]          rd_data
);

  logic [CHANNELS*WIDTH-1:0] next_flat;
  logic [WIDTH-1:0]          rd_next;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    counter_bank_chan #(.WIDTH(WIDTH)) u_chan (
      .clock      (clock),
      .reset      (reset),
      .en         (en[g]),
      .dir        (dir[g]),
      .sat        (sat[g]),
      .clr        (clr[g]),
      .load       (load[g]),
      .load_val   (load_val[g*WIDTH +: WIDTH]),
      .count      (count[g*WIDTH +: WIDTH]),
      .ovf        (ovf[g]),
      .next_count (next_flat[g*WIDTH +: WIDTH])
    );
  end

  // Selecting the post-update value keeps rd_data aligned with count; unmatched selectors read 0
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SELW'(i)) rd_next = next_flat[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= rd_next;
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - directed and randomized checks of counter_bank against a behavioural model
module tb_counter_bank;

  localparam int W  = 4;
  localparam int CH = 4;
  localparam int MAXV = 15;

  logic            clock = 1'b0;
  logic            reset;
  logic [CH-1:0]   en, dir, sat, clr, load;
  logic [CH*W-1:0] load_val;
  logic [1:0]      rd_sel;
  logic [CH*W-1:0] count;
  logic [CH-1:0]   ovf;
  logic [W-1:0]    rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int exp_cnt [CH];
  bit exp_ovf [CH];
  int exp_rd;

  always #5 clock = ~clock;

  counter_bank #(.WIDTH(W), .CHANNELS(CH), .SELW(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .sat      (sat),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .ovf      (ovf),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the rules, one update per rising edge
  always @(posedge clock) begin
    for (int i = 0; i < CH; i++) begin
      int n;
      exp_ovf[i] = 1'b0;
      if (!reset) begin
        exp_cnt[i] = 0;
      end else if (clr[i]) begin
        exp_cnt[i] = 0;
      end else if (load[i]) begin
        exp_cnt[i] = int'(load_val[i*W +: W]);
      end else if (en[i]) begin
        n = exp_cnt[i] + (dir[i] ? 1 : -1);
        if (n > MAXV || n < 0) begin
          exp_ovf[i] = 1'b1;
          if (!sat[i]) exp_cnt[i] = (n + MAXV + 1) % (MAXV + 1);
        end else begin
          exp_cnt[i] = n;
        end
      end
    end
    exp_rd = (!reset) ? 0 : exp_cnt[rd_sel];
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic [CH*W-1:0] ec;
      logic [CH-1:0]   eo;
      for (int i = 0; i < CH; i++) begin
        ec[i*W +: W] = W'(exp_cnt[i]);
        eo[i]        = exp_ovf[i];
      end
      check("count", 64'(count), 64'(ec));
      check("ovf", 64'(ovf), 64'(eo));
      check("rd_data", 64'(rd_data), 64'(exp_rd));
    end
  end

  function automatic logic [W-1:0] cnt(input int ch);
    return count[ch*W +: W];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    en = '0; dir = '0; sat = '0; clr = '0; load = '0; load_val = '0;
  endtask

  initial begin
    reset = 1'b0; idle(); rd_sel = 2'd0;
    en = 4'hF; dir = 4'hF;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_count", 64'(count), 64'h0);
    check("reset_ovf", 64'(ovf), 64'h0);
    check("reset_rd", 64'(rd_data), 64'h0);

    reset = 1'b1; idle(); en = 4'b0001; dir = 4'b0001;
    tick();
    check("first_up_ch0", 64'(cnt(0)), 64'd1);

    // ch0 wrap-up from 14
    idle(); load[0] = 1'b1; load_val[3:0] = 4'd14;
    tick();
    idle(); en[0] = 1'b1; dir[0] = 1'b1;
    tick();
    check("wrap_15", 64'(cnt(0)), 64'd15);
    check("wrap_15_ovf", 64'(ovf[0]), 64'd0);
    tick();
    check("wrap_0", 64'(cnt(0)), 64'd0);
    check("wrap_0_ovf", 64'(ovf[0]), 64'd1);
    check("model_wrap_ovf", 64'(exp_ovf[0]), 64'd1);
    tick();
    check("wrap_1", 64'(cnt(0)), 64'd1);
    check("wrap_1_ovf", 64'(ovf[0]), 64'd0);

    // ch1 saturate down from 1
    idle(); load[1] = 1'b1; load_val[7:4] = 4'd1;
    tick();
    idle(); en[1] = 1'b1; sat[1] = 1'b1;
    tick();
    check("sat_s1", 64'(cnt(1)), 64'd0);
    check("sat_s1_ovf", 64'(ovf[1]), 64'd0);
    tick();
    check("sat_s2", 64'(cnt(1)), 64'd0);
    check("sat_s2_ovf", 64'(ovf[1]), 64'd1);
    tick();
    check("sat_s3", 64'(cnt(1)), 64'd0);
    check("sat_s3_ovf", 64'(ovf[1]), 64'd1);
    check("model_sat_cnt", 64'(exp_cnt[1]), 64'd0);

    // ch2 priority clr > load > en
    idle(); clr[2] = 1'b1; load[2] = 1'b1; en[2] = 1'b1; dir[2] = 1'b1; load_val[11:8] = 4'd9;
    tick();
    check("prio_clr", 64'(cnt(2)), 64'd0);
    clr[2] = 1'b0;
    tick();
    check("prio_load", 64'(cnt(2)), 64'd9);
    check("prio_load_ovf", 64'(ovf[2]), 64'd0);

    // ch3 reset mid-count, read port tracking
    idle(); rd_sel = 2'd3; load[3] = 1'b1; load_val[15:12] = 4'd5;
    tick();
    idle(); en[3] = 1'b1; dir[3] = 1'b1;
    tick();
    tick();
    check("mid_7", 64'(cnt(3)), 64'd7);
    check("mid_rd_7", 64'(rd_data), 64'd7);
    reset = 1'b0;
    tick();
    check("mid_reset", 64'(cnt(3)), 64'd0);
    check("mid_reset_rd", 64'(rd_data), 64'd0);
    reset = 1'b1;
    tick();
    check("mid_resume", 64'(cnt(3)), 64'd1);
    check("mid_resume_rd", 64'(rd_data), 64'd1);

    // read sweep across distinct values
    idle(); load = 4'hF; load_val = 16'h5C83;
    tick();
    idle();
    for (int s = 0; s < CH; s++) begin
      logic [15:0] vals;
      vals = 16'h5C83;
      rd_sel = 2'(s);
      tick();
      check("sweep_rd", 64'(rd_data), 64'(vals[s*W +: W]));
      check("sweep_hold", 64'(count), 64'h5C83);
    end

    // randomized traffic, checked every cycle by the compare process
    for (int k = 0; k < 2000; k++) begin
      reset    = ($urandom_range(0, 63) != 0);
      en       = 4'($urandom);
      dir      = 4'($urandom);
      sat      = 4'($urandom);
      clr      = 4'($urandom) & 4'($urandom) & 4'($urandom);
      load     = 4'($urandom) & 4'($urandom);
      load_val = 16'($urandom);
      rd_sel   = 2'($urandom);
      tick();
    end

    @(negedge clock);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
